// File: rtl/lcd_drawmod_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lcd_drawmod_pkg
// Brief   : Shared types, image geometry and clipping helper for the
//           rectangle fill engine.
// Revision: 1.0 - initial release
// ============================================================================
package lcd_drawmod_pkg;

   localparam int IMG_W_DEF = 128;
   localparam int IMG_H_DEF = 128;
   localparam int COL_W     = 7;
   localparam int ROW_W     = 7;
   localparam int ADDR_W    = ROW_W + COL_W;
   localparam int LEN_W     = 8;
   localparam int COLOR_W   = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_WAITVB = 3'd2,
      ST_FILL   = 3'd3,
      ST_DONE   = 3'd4
   } draw_state_t;

   // Length clipped against the space left between origin and image edge.
   function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] len,
                                                 input logic [COL_W-1:0] org,
                                                 input logic [LEN_W-1:0] lim);
      logic [LEN_W-1:0] room;
      room = (lim > {1'b0, org}) ? (lim - {1'b0, org}) : '0;
      return (len < room) ? len : room;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rastcnt.sv
`default_nettype none
// ============================================================================
// Module  : lcd_rastcnt
// Brief   : Column/row raster counter pair with clipped end values and a
//           last-pixel flag; column is the inner loop.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_rastcnt
   import lcd_drawmod_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [COL_W-1:0] i_x,
   input  logic [ROW_W-1:0] i_y,
   input  logic [COL_W-1:0] i_end_col,
   input  logic [ROW_W-1:0] i_end_row,
   input  logic             i_step,
   output logic [COL_W-1:0] o_col,
   output logic [ROW_W-1:0] o_row,
   output logic             o_last
);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_x0;
   logic [COL_W-1:0] r_end_col;
   logic [ROW_W-1:0] r_end_row;
   logic             w_col_end;
   logic             w_last;

   assign w_col_end = (r_col == r_end_col);
   assign w_last    = w_col_end && (r_row == r_end_row);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_x0      <= '0;
         r_end_col <= '0;
         r_end_row <= '0;
      end else if (i_load) begin
         r_col     <= i_x;
         r_row     <= i_y;
         r_x0      <= i_x;
         r_end_col <= i_end_col;
         r_end_row <= i_end_row;
      end else if (i_step && !w_last) begin
         // Counters hold on the last pixel so the address stays put after fill.
         if (w_col_end) begin
            r_col <= r_x0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/lcd_drawmod.sv
`default_nettype none
// ============================================================================
// Module  : lcd_drawmod
// Brief   : Solid rectangle fill engine; drives port A of the dual-port
//           picture RAM whose port B is scanned by the LCD timing stage.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_drawmod
   import lcd_drawmod_pkg::*;
#(
   parameter int IMG_W       = IMG_W_DEF,
   parameter int IMG_H       = IMG_H_DEF,
   parameter bit WAIT_VBLANK = 1'b1
)
(
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               iCall,
   input  logic [COL_W-1:0]   iX,
   input  logic [ROW_W-1:0]   iY,
   input  logic [LEN_W-1:0]   iW,
   input  logic [LEN_W-1:0]   iH,
   input  logic [COLOR_W-1:0] iColor,
   input  logic               iVBlank,
   output logic               oBusy,
   output logic               oDone,
   output logic               oWrEn,
   output logic [ADDR_W-1:0]  oAddr,
   output logic [COLOR_W-1:0] oData
);

   localparam logic [LEN_W-1:0] c_IMG_W = LEN_W'(IMG_W);
   localparam logic [LEN_W-1:0] c_IMG_H = LEN_W'(IMG_H);

   draw_state_t        r_state;
   draw_state_t        w_state_next;

   logic [COL_W-1:0]   r_x;
   logic [ROW_W-1:0]   r_y;
   logic [LEN_W-1:0]   r_w;
   logic [LEN_W-1:0]   r_h;
   logic [COLOR_W-1:0] r_color;
   logic               r_wr_en;

   logic               w_accept;
   logic [LEN_W-1:0]   w_weff;
   logic [LEN_W-1:0]   w_heff;
   logic               w_empty;
   logic [COL_W-1:0]   w_end_col;
   logic [ROW_W-1:0]   w_end_row;
   logic [COL_W-1:0]   w_col;
   logic [ROW_W-1:0]   w_row;
   logic               w_last;

   assign w_accept  = (r_state == ST_IDLE) && iCall;
   assign w_weff    = clip_len(r_w, r_x, c_IMG_W);
   assign w_heff    = clip_len(r_h, r_y, c_IMG_H);
   assign w_empty   = (w_weff == '0) || (w_heff == '0);
   // Modulo-128 arithmetic also covers the full-width case (Weff = 128).
   assign w_end_col = r_x + w_weff[COL_W-1:0] - 7'd1;
   assign w_end_row = r_y + w_heff[ROW_W-1:0] - 7'd1;

   lcd_rastcnt u_rastcnt (
      .clk       (CLOCK),
      .rst_n     (RESET),
      .i_load    (r_state == ST_SETUP),
      .i_x       (r_x),
      .i_y       (r_y),
      .i_end_col (w_end_col),
      .i_end_row (w_end_row),
      .i_step    (r_state == ST_FILL),
      .o_col     (w_col),
      .o_row     (w_row),
      .o_last    (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (iCall) w_state_next = ST_SETUP;
         end
         ST_SETUP: begin
            if (w_empty)          w_state_next = ST_DONE;
            else if (WAIT_VBLANK) w_state_next = ST_WAITVB;
            else                  w_state_next = ST_FILL;
         end
         ST_WAITVB: begin
            if (iVBlank) w_state_next = ST_FILL;
         end
         ST_FILL: begin
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_color <= '0;
         r_wr_en <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Write strobe leads the FILL state by one register so it is high
         // in exactly the FILL cycles, aligned with the counter address.
         r_wr_en <= (w_state_next == ST_FILL);
         if (w_accept) begin
            r_x     <= iX;
            r_y     <= iY;
            r_w     <= iW;
            r_h     <= iH;
            r_color <= iColor;
         end
      end
   end

   assign oBusy = (r_state == ST_SETUP) || (r_state == ST_WAITVB) ||
                  (r_state == ST_FILL);
   assign oDone = (r_state == ST_DONE);
   assign oWrEn = r_wr_en;
   assign oAddr = {w_row, w_col};
   assign oData = r_color;

endmodule
`default_nettype wire
